// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer_if
// Description : Byte handover between the IO controller and the UART
//               transmitter: tx_start/data_in request, tx_done/busy status,
//               and the serial tx line.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_serializer_if;
   logic       tx_start;
   logic [7:0] data_in;
   logic       tx;
   logic       tx_done;
   logic       busy;

   // Controller side: requests a byte and watches completion
   modport master (
      output tx_start,
      output data_in,
      input  tx,
      input  tx_done,
      input  busy
   );

   // Serializer side: accepts a byte and drives the line
   modport slave (
      input  tx_start,
      input  data_in,
      output tx,
      output tx_done,
      output busy
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART transmitter. Frames one byte per accepted tx_start as
//               start bit, 8 data bits LSB first, optional parity bit and
//               1 or 2 stop bits, then pulses tx_done for one cycle.
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input wire                  clk,
   input wire                  reset,
   uart_tx_serializer_if.slave bus
);

   // Baud counter width; a single-bit counter still works for the minimum of 2
   localparam int                 c_CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]         c_DATA_LAST = 3'd7;
   localparam logic [2:0]         c_STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic               c_ODD       = (PARITY_ODD != 0);
   localparam logic               c_PAR_EN    = (PARITY_EN != 0);

   // Illegal parameter combinations stop elaboration rather than misbehave
   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
         $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
      end
      if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
         $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t             r_state;
   logic [c_CNT_W-1:0] r_baud_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               r_parity;
   logic               r_tx;
   logic               r_tx_done;
   logic               r_busy;

   logic               w_bit_end;

   // A serial bit ends on the edge where the baud counter reaches its last value
   assign w_bit_end = (r_baud_cnt == c_CNT_LAST);

   assign bus.tx      = r_tx;
   assign bus.tx_done = r_tx_done;
   assign bus.busy    = r_busy;

   // Frame sequencer: state, baud timing, shifting and registered line outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_tx       <= 1'b1;
         r_tx_done  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_tx_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_tx       <= 1'b1;
               r_baud_cnt <= '0;
               r_bit_idx  <= '0;
               if (bus.tx_start) begin
                  // Byte and its parity are captured once; later data_in
                  // changes cannot reach the frame in flight
                  r_shift  <= bus.data_in;
                  r_parity <= (^bus.data_in) ^ c_ODD;
                  r_busy   <= 1'b1;
                  r_tx     <= 1'b0;
                  r_state  <= S_START;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  r_tx       <= r_shift[0];
                  r_state    <= S_DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  r_shift    <= {1'b0, r_shift[7:1]};
                  if (r_bit_idx == c_DATA_LAST) begin
                     r_bit_idx <= '0;
                     if (c_PAR_EN) begin
                        r_tx    <= r_parity;
                        r_state <= S_PARITY;
                     end else begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                     end
                  end else begin
                     // Next bit is the one about to land in shift[0]
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_tx      <= r_shift[1];
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
               end
            end

            S_PARITY: begin
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  r_tx       <= 1'b1;
                  r_state    <= S_STOP;
               end else begin
                  r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
               end
            end

            S_STOP: begin
               r_tx <= 1'b1;
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  // Bit index is reused to count stop bits
                  if (r_bit_idx == c_STOP_LAST) begin
                     r_bit_idx <= '0;
                     r_tx_done <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
               end
            end

            S_DONE: begin
               // tx_start here is deliberately ignored
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_tx       <= 1'b1;
               r_busy     <= 1'b0;
               r_baud_cnt <= '0;
               r_bit_idx  <= '0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmitter that serializes bytes handed over by the IO controller onto the serial line to the host computer. It is the transmit-side end of the IO controller's tx_start/tx_done handshake. The controller pulses tx_start with a byte on data_in. This block frames the byte (start, 8 data bits LSB-first, optional parity, stop bits), then pulses tx_done. Data comes from the DRAM read port; the output drives the board TX pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); must be >= 2
PARITY_EN, 0, 1 = insert a parity bit after data bit 7
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
tx_start  input  1  one-cycle request to send data_in; honoured only in IDLE
data_in  input  8  byte to transmit, sampled on the accepting edge only
tx  output  1  serial line, idle high, registered
tx_done  output  1  one-cycle pulse at frame completion
busy  output  1  high from acceptance until return to IDLE

Behaviour:
- Reset (async, active-high, any state): tx = 1, tx_done = 0, busy = 0, state = IDLE, baud counter = 0, bit index = 0, shift register = 0. Reset mid-frame aborts the frame with no tx_done. tx goes high immediately.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: tx = 1. If tx_start = 1 at edge E0: latch data_in into shift register, compute parity bit (XOR of data_in, inverted if PARITY_ODD), set busy = 1, tx = 0, go to START. tx_start in any other state is ignored, with no queuing.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 in each bit state. The bit ends on the edge where count = CLKS_PER_BIT-1; the counter resets to 0 on that edge.
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with tx = shift[0].
- DATA: each bit lasts CLKS_PER_BIT cycles, LSB first. The shift register shifts right at each bit end. The 3-bit index counts 0..7. After bit 7, go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles. At the final edge, go to DONE and set tx_done = 1.
- DONE: exactly one cycle with tx_done = 1, tx = 1 and busy = 1. On the next edge: tx_done = 0, busy = 0, go to IDLE. tx_start during DONE is ignored.
- Latency: the frame occupies edges E0 to E0 + (9 + PARITY_EN + STOP_BITS)*CLKS_PER_BIT. tx_done is high in the cycle that follows that final edge.
- Minimum re-accept: a new tx_start is accepted 2 cycles after the tx_done edge. This is compatible with the IO controller's TX_4→TX_1→TX_2 sequence.
- data_in changes after E0 do not affect the frame in flight.
- tx is a register output; it never glitches between bit boundaries.

Test Plan:
- Reset with CLKS_PER_BIT = 4 and PARITY_EN = 0: tx = 1, tx_done = 0, busy = 0 immediately on reset assertion, without waiting for a clk edge.
- Send 0x55 with CLKS_PER_BIT = 4, STOP_BITS = 1: tx levels per 4-cycle bit are 0,1,0,1,0,1,0,1,0,1. tx_done pulses exactly once, one cycle, at edge E0+40. busy falls at E0+41.
- Send 0x07 with PARITY_EN = 1, even parity: parity bit = 1. With PARITY_ODD = 1: parity bit = 0. tx_done at E0+44 in both cases.
- Send 0xA3 with STOP_BITS = 2: tx stays high for 8 cycles after bit 7 (CLKS_PER_BIT = 4). tx_done at E0+44.
- Pulse tx_start mid-frame and during DONE, changing data_in each time: both are ignored and the original byte is sent intact. A tx_start 2 cycles after tx_done starts a new frame (tx low the next cycle).
- Assert reset during DATA bit 3, then release: tx = 1 at once and no tx_done. A following tx_start with 0xFF sends a clean frame.
